// File: rtl/mmio_pkg.sv
// Shared types and defaults for the MMIO slot master.
// MMIO_ERR_DATA is what a decode error returns when MMIO_ADDR_CHECK_EN is defined.
package mmio_pkg;

   localparam int MMIO_SLOT_W = 6;
   localparam int MMIO_REG_AW = 5;
   localparam int MMIO_DW     = 32;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } mmio_state_t;

   localparam logic [31:0] MMIO_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mmio_slot_decode.sv
// Slot index to one-hot chip-select decoder with range flag; purely combinational.
module mmio_slot_decode
   import mmio_pkg::*;
#(
   parameter int NUM_SLOTS = 48,
   parameter int SLOT_W    = MMIO_SLOT_W
) (
   input  logic [SLOT_W-1:0]    slot_idx,
   output logic [NUM_SLOTS-1:0] cs,
   output logic                 in_range
);

   always_comb begin
      cs = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         cs[i] = (slot_idx == SLOT_W'(i));
      end
      in_range = ({{(32-SLOT_W){1'b0}}, slot_idx} < 32'(NUM_SLOTS));
   end

endmodule

// File: rtl/mmio_slot_master.sv
// Initiator end of the MMIO slot interface: one single-beat transaction in flight.
// Optional MMIO_ADDR_CHECK_EN: out-of-range slots suppress the strobe and return an error.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a host request
// ACCESS | one cycle: cs and read/write strobe driven to the slots
// RESP   | rsp_valid high, response held until the host takes it
module mmio_slot_master
   import mmio_pkg::*;
#(
   parameter int NUM_SLOTS = 48,
   parameter int SLOT_W    = MMIO_SLOT_W,
   parameter int REG_AW    = MMIO_REG_AW,
   parameter int DW        = MMIO_DW
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [SLOT_W+REG_AW-1:0]  req_addr,
   input  logic [DW-1:0]             req_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DW-1:0]             rsp_rdata,
   output logic                      rsp_err,
   output logic [NUM_SLOTS-1:0]      slot_cs,
   output logic [REG_AW-1:0]         slot_address,
   output logic [DW-1:0]             slot_wr_data,
   output logic                      slot_read,
   output logic                      slot_write,
   input  logic [NUM_SLOTS*DW-1:0]   slot_rd_data
);

`ifdef MMIO_ADDR_CHECK_EN
   localparam bit ADDR_CHECK = 1'b1;
`else
   localparam bit ADDR_CHECK = 1'b0;
`endif

   mmio_state_t state;
   mmio_state_t state_nxt;

   logic                 rdy_en;
   logic                 accept;
   logic [NUM_SLOTS-1:0] dec_cs;
   logic                 dec_in_range;
   logic [NUM_SLOTS-1:0] cs_q;
   logic                 wr_q;
   logic                 in_range_q;
   logic                 err_hit;
   logic [DW-1:0]        rd_sel;
   logic [DW-1:0]        rsp_rdata_d;

   mmio_slot_decode #(
      .NUM_SLOTS (NUM_SLOTS),
      .SLOT_W    (SLOT_W)
   ) u_decode (
      .slot_idx (req_addr[REG_AW +: SLOT_W]),
      .cs       (dec_cs),
      .in_range (dec_in_range)
   );

   // Keeps req_ready low while reset is asserted even though state sits in IDLE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) rdy_en <= 1'b0;
      else          rdy_en <= 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)    state_nxt = ACCESS;
         ACCESS:                 state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   assign accept  = (state == IDLE) && rdy_en && req_valid;
   assign err_hit = ADDR_CHECK && !in_range_q;

   always_comb begin
      req_ready  = (state == IDLE) && rdy_en;
      rsp_valid  = (state == RESP);
      slot_cs    = '0;
      slot_read  = 1'b0;
      slot_write = 1'b0;
      if (state == ACCESS) begin
         slot_cs    = cs_q;
         slot_read  = !err_hit && !wr_q;
         slot_write = !err_hit && wr_q;
      end
   end

   // cs_q is one-hot or zero, so an OR-reduction mux is sufficient.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (cs_q[i]) rd_sel = rd_sel | slot_rd_data[i*DW +: DW];
      end
      if (err_hit)   rsp_rdata_d = DW'(MMIO_ERR_DATA);
      else if (wr_q) rsp_rdata_d = '0;
      else           rsp_rdata_d = rd_sel;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slot_address <= '0;
         slot_wr_data <= '0;
         cs_q         <= '0;
         wr_q         <= 1'b0;
         in_range_q   <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
      end else begin
         if (accept) begin
            slot_address <= req_addr[REG_AW-1:0];
            slot_wr_data <= req_wdata;
            cs_q         <= dec_cs;
            wr_q         <= req_write;
            in_range_q   <= dec_in_range;
         end
         if (state == ACCESS) begin
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= err_hit;
         end
      end
   end

endmodule

// File: tb/tb_mmio_slot_master.sv
// Scoreboard bench for mmio_slot_master: directed cases plus randomized traffic
// against array-based slot models; honours MMIO_ADDR_CHECK_EN when defined.
module tb_mmio_slot_master;

   localparam int NS = 48;
   localparam int SW = 6;
   localparam int AW = 5;
   localparam int DW = 32;

   typedef struct {
      logic [NS-1:0] cs;
      logic          wr;
      logic [AW-1:0] adr;
      logic [DW-1:0] wd;
   } stb_t;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } rsp_t;

   logic                clock = 1'b0;
   logic                reset_n = 1'b0;
   logic                req_valid = 1'b0;
   logic                req_ready;
   logic                req_write = 1'b0;
   logic [SW+AW-1:0]    req_addr = '0;
   logic [DW-1:0]       req_wdata = '0;
   logic                rsp_valid;
   logic                rsp_ready = 1'b0;
   logic [DW-1:0]       rsp_rdata;
   logic                rsp_err;
   logic [NS-1:0]       slot_cs;
   logic [AW-1:0]       slot_address;
   logic [DW-1:0]       slot_wr_data;
   logic                slot_read;
   logic                slot_write;
   logic [NS*DW-1:0]    slot_rd_data;

   logic [DW-1:0] smem    [NS][32];
   logic [DW-1:0] ref_mem [NS][32];

   stb_t str_q[$];
   rsp_t exp_q[$];
   stb_t mon_s;
   rsp_t mon_r;

   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   int   last_acc = 0;
   int   hs_cyc = 0;
   bit   rnd_rdy = 1'b0;
   logic prev_valid = 1'b0;
   logic prev_stall = 1'b0;
   logic [DW-1:0] prev_rdata = '0;
   logic prev_err = 1'b0;

   mmio_slot_master #(
      .NUM_SLOTS (NS),
      .SLOT_W    (SW),
      .REG_AW    (AW),
      .DW        (DW)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .slot_cs      (slot_cs),
      .slot_address (slot_address),
      .slot_wr_data (slot_wr_data),
      .slot_read    (slot_read),
      .slot_write   (slot_write),
      .slot_rd_data (slot_rd_data)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Slot cores: combinational read by address, write on cs & strobe.
   always_comb begin
      for (int i = 0; i < NS; i++) slot_rd_data[i*DW +: DW] = smem[i][slot_address];
   end

   always @(posedge clock) begin
      if (slot_write) begin
         for (int i = 0; i < NS; i++) if (slot_cs[i]) smem[i][slot_address] <= slot_wr_data;
      end
   end

   always @(posedge clock) begin
      if (rnd_rdy) begin
         #1 rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference model: computes strobe and response from the slot index range rules.
   task automatic issue(input logic wr, input int slot, input int rg,
                        input logic [DW-1:0] wd, output int acc);
      stb_t s;
      rsp_t r;
      bit   in_rng;
      bit   strobe;
      bit   done;
      in_rng = (slot < NS);
      s.cs   = '0;
      if (in_rng) s.cs[slot] = 1'b1;
      s.wr   = wr;
      s.adr  = AW'(rg);
      s.wd   = wd;
`ifdef MMIO_ADDR_CHECK_EN
      strobe  = in_rng;
      r.err   = !in_rng;
      r.rdata = !in_rng ? 32'hDEAD_BEEF : (wr ? 32'h0 : ref_mem[slot][rg]);
`else
      strobe  = 1'b1;
      r.err   = 1'b0;
      r.rdata = (wr || !in_rng) ? 32'h0 : ref_mem[slot][rg];
`endif
      if (wr && in_rng) ref_mem[slot][rg] = wd;
      if (strobe) str_q.push_back(s);
      exp_q.push_back(r);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = {SW'(slot), AW'(rg)};
      req_wdata = wd;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clock);
         if (req_ready) begin
            @(posedge clock);
            #1;
            done = 1'b1;
         end
      end
      if (!done) chk("accept_timeout", 64'(req_ready), 64'(1));
      req_valid = 1'b0;
      acc       = cyc;
      last_acc  = cyc;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && !(req_ready && !rsp_valid && exp_q.size() == 0); i++)
         @(posedge clock);
      #1;
   endtask

   // Monitor: strobe and response checks against the expectation queues.
   always @(negedge clock) begin
      if (!reset_n) begin
         prev_valid = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (slot_read || slot_write) begin
            chk("ready_low_access", 64'(req_ready), 64'(0));
            chk("strobe_latency", 64'(cyc), 64'(last_acc));
            if (str_q.size() == 0) begin
               chk("unexpected_strobe", 64'({slot_read, slot_write}), 64'(0));
            end else begin
               mon_s = str_q.pop_front();
               chk("strobe_cs", 64'(slot_cs), 64'(mon_s.cs));
               chk("strobe_read", 64'(slot_read), 64'(!mon_s.wr));
               chk("strobe_write", 64'(slot_write), 64'(mon_s.wr));
               chk("strobe_address", 64'(slot_address), 64'(mon_s.adr));
               if (mon_s.wr) chk("strobe_wdata", 64'(slot_wr_data), 64'(mon_s.wd));
            end
         end else if (slot_cs != '0) begin
            chk("cs_without_strobe", 64'(slot_cs), 64'(0));
         end
         if (rsp_valid) begin
            chk("ready_low_resp", 64'(req_ready), 64'(0));
            if (!prev_valid) chk("rsp_latency", 64'(cyc), 64'(last_acc + 1));
            if (prev_stall) begin
               chk("stall_rdata_stable", 64'(rsp_rdata), 64'(prev_rdata));
               chk("stall_err_stable", 64'(rsp_err), 64'(prev_err));
            end
            if (rsp_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
               end else begin
                  mon_r = exp_q.pop_front();
                  chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_r.rdata));
                  chk("rsp_err", 64'(rsp_err), 64'(mon_r.err));
               end
               hs_cyc = cyc;
            end
         end
         prev_valid = rsp_valid;
         prev_stall = rsp_valid && !rsp_ready;
         prev_rdata = rsp_rdata;
         prev_err   = rsp_err;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int a2;
      int accs[4];
      int slot;
      for (int i = 0; i < NS; i++)
         for (int j = 0; j < 32; j++) begin
            smem[i][j]    = $urandom;
            ref_mem[i][j] = smem[i][j];
         end
      smem[2][1]    = 32'h0000_1234;
      ref_mem[2][1] = 32'h0000_1234;

      repeat (3) @(posedge clock);
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
      chk("rst_rsp_err", 64'(rsp_err), 64'(0));
      chk("rst_slot_cs", 64'(slot_cs), 64'(0));
      chk("rst_strobes", 64'({slot_read, slot_write}), 64'(0));
      chk("rst_slot_address", 64'(slot_address), 64'(0));
      chk("rst_slot_wr_data", 64'(slot_wr_data), 64'(0));
      @(negedge clock);
      reset_n = 1'b1;
      #1 chk("release_ready_low", 64'(req_ready), 64'(0));
      @(posedge clock);
      #1 chk("release_ready_high", 64'(req_ready), 64'(1));

      rsp_ready = 1'b1;
      // Timer at slot 2: write then read back a preset register.
      issue(1'b1, 2, 0, 32'h2, a);
      #1;
      chk("t1_cs", 64'(slot_cs), 64'h4);
      chk("t1_write", 64'(slot_write), 64'(1));
      wait_idle();
      issue(1'b0, 2, 1, $urandom, a);
      wait_idle();
      issue(1'b0, 2, 0, $urandom, a);
      wait_idle();

      // Backpressure with a second request queued behind it.
      rsp_ready = 1'b0;
      issue(1'b0, 5, 3, $urandom, a);
      fork
         issue(1'b0, 7, 4, $urandom, a2);
         begin
            repeat (6) @(posedge clock);
            #1 rsp_ready = 1'b1;
         end
      join
      chk("accept_after_handshake", 64'(a2), 64'(hs_cyc + 2));
      wait_idle();

      // Out-of-range slot 50, read and write.
      issue(1'b0, 50, 0, $urandom, a);
      wait_idle();
      issue(1'b1, 50, 3, $urandom, a);
      wait_idle();

      // Back-to-back with rsp_ready held high.
      for (int i = 0; i < 4; i++) issue(1'b0, $urandom_range(0, NS-1), $urandom_range(0, 31), $urandom, accs[i]);
      for (int i = 1; i < 4; i++) chk("b2b_spacing", 64'(accs[i] - accs[i-1]), 64'(3));
      wait_idle();

      // Reset during the ACCESS cycle.
      issue(1'b0, 9, 2, 32'h0, a);
      #1 chk("rst_mid_strobe_seen", 64'(slot_read), 64'(1));
      reset_n = 1'b0;
      #1;
      chk("rst_mid_cs", 64'(slot_cs), 64'(0));
      chk("rst_mid_strobes", 64'({slot_read, slot_write}), 64'(0));
      chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
      exp_q.delete();
      str_q.delete();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1 chk("rst_mid_ready_low", 64'(req_ready), 64'(0));
      @(posedge clock);
      #1 chk("rst_mid_ready_high", 64'(req_ready), 64'(1));
      repeat (3) @(posedge clock);
      #1 chk("rst_mid_no_rsp", 64'(rsp_valid), 64'(0));

      // Randomized traffic with random backpressure.
      rnd_rdy = 1'b1;
      for (int n = 0; n < 150; n++) begin
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
         slot = ($urandom_range(0, 4) != 0) ? int'($urandom_range(0, NS-1)) : int'($urandom_range(0, 63));
         issue(1'($urandom_range(0, 1)), slot, $urandom_range(0, 31), $urandom, a);
      end
      rnd_rdy = 1'b0;
      @(posedge clock);
      #2 rsp_ready = 1'b1;
      wait_idle();
      chk("drain_rsp_queue", 64'(exp_q.size()), 64'(0));
      chk("drain_strobe_queue", 64'(str_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
